dti_noc_inj_pkt_buf: RTL and testbench
======================================

# dti_noc_inj_pkt_buf

Packet-atomic injection buffer on the NoC side of the DTI_PR request path. It consumes 104-bit flits popped from the request async-FIFO master (`{payload[89:0], srcid[5:0], tgtid[5:0], qos, last}`) and presents them to the NoC router injection port. By default it only releases a packet once its last flit is buffered, so the router never sees a stalled half-packet. It also enforces a maximum packet length and supports a synchronous flush on partial reset.

## Interface
- `DEPTH`, 16: flit entries; power of two, ≥ `MAX_PKT_FLITS`.
- `MAX_PKT_FLITS`, 8: longest legal packet in flits; ≥ 2.
- `DATA_WIDTH`, 104: flit width; fixed by the packing below.
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: partial reset; level-sensitive.
- `idle` out 1: buffer empty, no flush in progress, no partial packet pending.
- `s_vld` in 1: input flit valid.
- `s_pld` in 104: `[103:14]` payload, `[13:8]` srcid, `[7:2]` tgtid, `[1]` qos, `[0]` last.
- `s_rdy` out 1: input ready.
- `m_vld` out 1: output flit valid.
- `m_pld` out 104: same packing as `s_pld`.
- `m_rdy` in 1: router ready.
- `pkt_cnt` out $clog2(DEPTH)+1: complete packets held.
- `err_long_pkt` out 1: sticky over-length error; cleared only by `rst`.

## Operation
- Storage is a flop array with wptr/rptr, $clog2(DEPTH) bits, wrapping at DEPTH. Flit count is $clog2(DEPTH)+1 bits.
- Push occurs when `s_vld && s_rdy`. `s_rdy = (state==RUN) && (count < DEPTH)`. There is no bypass: at full, `s_rdy=0` even if a pop occurs in the same cycle.
- Pop occurs when `m_vld && m_rdy`. `m_pld` = entry at rptr.
- Store-and-forward (default): `m_vld = (state==RUN) && (pkt_cnt > 0)`.
- `pkt_cnt`: +1 on a push with last=1; −1 on a pop with last=1; a simultaneous +1/−1 leaves it unchanged.
- Length counter `in_len` (in flits) tracks the packet being received.
  - On each push it increments; it resets to 0 on a push with last=1.
  - If a push without last occurs when `in_len == MAX_PKT_FLITS-1`, the flit is stored with bit[0] forced to 1, `err_long_pkt` is set, and `in_len` resets.
  - The next input flit starts a new packet.
- The `DEPTH ≥ MAX_PKT_FLITS` rule guarantees that a full buffer always contains a complete packet, so store-and-forward cannot deadlock.
- FSM states:
  - RUN: normal operation. `flush=1` → FLUSH.
  - FLUSH: one cycle. wptr, rptr, count, `pkt_cnt` and `in_len` are cleared; `s_rdy=0`, `m_vld=0`. Always → HOLD.
  - HOLD: `s_rdy=0`, `m_vld=0`. `flush=0` → RUN.
- `err_long_pkt` is not cleared by flush.
- `idle = (state==RUN) && (count==0) && (in_len==0)`.

## Timing
- Reset values: `s_rdy=0` in the reset cycle, then 1. `m_vld=0`, `m_pld=0`, `pkt_cnt=0`, `err_long_pkt=0`, `idle=1`. The FSM enters RUN.
- Latency: a last flit pushed in cycle N gives `m_vld=1` in N+1 with the head flit of that packet, provided it is the first complete packet.
- `m_pld` holds stable while `m_vld && !m_rdy`. `m_vld` does not drop without a pop, except on flush.
- Flush asserted in cycle N: the cycle-N push/pop still completes. State is FLUSH in N+1, where the clear happens. HOLD lasts from N+2 while `flush` is high. RUN resumes the cycle after `flush` falls.
- `rst` overrides `flush` in the same cycle.

## Configuration
- `DTI_NOC_INJ_CUT_THROUGH_EN`
  - Defined: `m_vld = (state==RUN) && (count > 0)`. Flits forward one cycle after push, regardless of packet completion. `pkt_cnt` is still maintained.
  - Undefined: store-and-forward as above.

## Structure
- In `dti_pack`:
  - `typedef struct packed` `dti_noc_flit_t` `{payload[89:0], srcid[5:0], tgtid[5:0], qos, last}`.
  - Constants `DTI_FLIT_WIDTH=104`, `DTI_FLIT_PLD_WIDTH=90`, `DTI_NOC_ID_WIDTH=6`.
  - FSM enum `dti_inj_state_e {RUN, FLUSH, HOLD}`.
- One sub-module, `dti_noc_inj_flop_ram`: DEPTH×DATA_WIDTH flop array, one write port, one async read port. Pointers, counters, FSM and length check live in the top.

## Test plan
- Store-and-forward: push a 3-flit packet with 1-cycle gaps and `m_rdy=1` → `m_vld` stays 0 until the cycle after the last push, then 3 consecutive pops; `pkt_cnt` goes 1→0.
- Full and back-pressure: `m_rdy=0`, push 16 single-flit packets → `s_rdy=0` at count 16, `pkt_cnt=16`; one pop then frees a single push.
- Over-length: push 9 flits without last (MAX=8) → 8th flit is output with last=1 and `err_long_pkt=1`; 9th flit heads the next packet.
- Flush mid-packet: 2 flits of a 4-flit packet buffered, pulse `flush` for 3 cycles → `m_vld` never rises; FLUSH then HOLD×2; `idle=1` after return to RUN; `err_long_pkt` unchanged.
- Simultaneous last push and last pop with `pkt_cnt=1` → `pkt_cnt` stays 1 and `m_vld` stays 1.
- With `DTI_NOC_INJ_CUT_THROUGH_EN` defined: push the first flit of a 4-flit packet → `m_vld=1` next cycle with that flit and `pkt_cnt=0`.

Source files
------------

// File: rtl/dti_pack.sv
// Shared types for the DTI_PR NoC injection path: flit packing and the
// injection buffer FSM encoding.
package dti_pack;

    localparam int DTI_FLIT_WIDTH     = 104;
    localparam int DTI_FLIT_PLD_WIDTH = 90;
    localparam int DTI_NOC_ID_WIDTH   = 6;

    typedef struct packed {
        logic [DTI_FLIT_PLD_WIDTH-1:0] payload;
        logic [DTI_NOC_ID_WIDTH-1:0]   srcid;
        logic [DTI_NOC_ID_WIDTH-1:0]   tgtid;
        logic                          qos;
        logic                          last;
    } dti_noc_flit_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } dti_inj_state_e;

endpackage

// File: rtl/dti_noc_inj_flop_ram.sv
// DEPTH x DATA_WIDTH flop storage for the injection buffer: one synchronous
// write port, one asynchronous read port.
module dti_noc_inj_flop_ram #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 104
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dti_noc_inj_pkt_buf.sv
// Packet-atomic NoC injection buffer with max-length enforcement and flush.
// Define DTI_NOC_INJ_CUT_THROUGH_EN to forward flits before packets complete.
module dti_noc_inj_pkt_buf
    import dti_pack::*;
#(
    parameter int DEPTH         = 16,
    parameter int MAX_PKT_FLITS = 8,
    parameter int DATA_WIDTH    = DTI_FLIT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    output logic                   idle,
    input  logic                   s_vld,
    input  logic [DATA_WIDTH-1:0]  s_pld,
    output logic                   s_rdy,
    output logic                   m_vld,
    output logic [DATA_WIDTH-1:0]  m_pld,
    input  logic                   m_rdy,
    output logic [$clog2(DEPTH):0] pkt_cnt,
    output logic                   err_long_pkt,
    output dti_inj_state_e         dbg_state
);

    // Handshake: a flit moves on a port in a cycle where valid and ready are
    // both high; valid never depends on ready on either side.
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = $clog2(MAX_PKT_FLITS);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [LW-1:0] LAST_LEN = LW'(MAX_PKT_FLITS - 1);

    dti_inj_state_e        state, state_nxt;
    logic [AW-1:0]         wptr, rptr;
    logic [CW-1:0]         count;
    logic [LW-1:0]         in_len;
    logic                  push, pop, len_over, push_last, pop_last;
    dti_noc_flit_t         in_flit, w_flit;
    logic [DATA_WIDTH-1:0] rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (flush) state_nxt = FLUSH;
            FLUSH:   state_nxt = HOLD;
            HOLD:    if (!flush) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    assign s_rdy = !rst && (state == RUN) && (count < FULL_CNT);
`ifdef DTI_NOC_INJ_CUT_THROUGH_EN
    assign m_vld = !rst && (state == RUN) && (count != '0);
`else
    assign m_vld = !rst && (state == RUN) && (pkt_cnt != '0);
`endif
    assign push = s_vld && s_rdy;
    assign pop  = m_vld && m_rdy;

    // An over-length packet is truncated by forcing last on its final legal flit.
    always_comb begin
        in_flit     = s_pld;
        len_over    = !in_flit.last && (in_len == LAST_LEN);
        w_flit      = in_flit;
        w_flit.last = in_flit.last | len_over;
    end

    assign push_last = push && w_flit.last;
    assign pop_last  = pop && rdata[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            pkt_cnt      <= '0;
            in_len       <= '0;
            err_long_pkt <= 1'b0;
        end else if (state == FLUSH) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            pkt_cnt <= '0;
            in_len  <= '0;
        end else begin
            if (push) begin
                wptr   <= wptr + 1'b1;
                in_len <= w_flit.last ? '0 : in_len + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            case ({push_last, pop_last})
                2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
                2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
                default: ;
            endcase
            if (push && len_over) begin
                err_long_pkt <= 1'b1;
            end
        end
    end

    dti_noc_inj_flop_ram #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wptr),
        .wdata (w_flit),
        .raddr (rptr),
        .rdata (rdata)
    );

    assign m_pld     = m_vld ? rdata : '0;
    assign idle      = (state == RUN) && (count == '0) && (in_len == '0);
    assign dbg_state = state;

endmodule

// File: tb/tb_dti_noc_inj_pkt_buf.sv
// Randomized bench for dti_noc_inj_pkt_buf: a queue-based packet model
// predicts every output each cycle.
module tb_dti_noc_inj_pkt_buf;
    import dti_pack::*;

    localparam int DEPTH  = 16;
    localparam int MAXF   = 8;
    localparam int W      = 104;
    localparam int NCYC   = 3000;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, flush, idle, s_vld, s_rdy, m_vld, m_rdy, err_long_pkt;
    logic [W-1:0]   s_pld, m_pld;
    logic [4:0]     pkt_cnt;
    dti_inj_state_e dbg_state;

    dti_noc_inj_pkt_buf #(
        .DEPTH         (DEPTH),
        .MAX_PKT_FLITS (MAXF),
        .DATA_WIDTH    (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .idle         (idle),
        .s_vld        (s_vld),
        .s_pld        (s_pld),
        .s_rdy        (s_rdy),
        .m_vld        (m_vld),
        .m_pld        (m_pld),
        .m_rdy        (m_rdy),
        .pkt_cnt      (pkt_cnt),
        .err_long_pkt (err_long_pkt),
        .dbg_state    (dbg_state)
    );

    // scoreboard / reference model state
    logic [W-1:0]   exp_q[$];
    int             pkt_flits;
    logic           exp_err;
    dti_inj_state_e mstate;
    int             checks = 0;
    int             errors = 0;
    int             cyc = 0;
    int             flush_left = 0;
    logic           e_s_rdy, e_m_vld;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int complete_pkts();
        int n = 0;
        foreach (exp_q[i]) if (exp_q[i][0]) n++;
        return n;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        pkt_flits = 0;
        exp_err   = 1'b0;
        mstate    = RUN;
    endtask

    // driver: phase-dependent random stimulus
    task automatic drive();
        logic [127:0] r;
        int ph, pos, last_pct, vld_pct, rdy_pct;
        ph  = (cyc / 250) % 4;
        pos = cyc % 250;
        case (ph)
            0:       begin vld_pct = 70; rdy_pct = 70; last_pct = 30; end
            1:       begin vld_pct = 90; rdy_pct = (pos > 80) ? 60 : 0; last_pct = 85; end
            2:       begin vld_pct = 80; rdy_pct = 50; last_pct = 5; end
            default: begin vld_pct = 70; rdy_pct = 60; last_pct = 25; end
        endcase
        rst = (cyc < 2) || (cyc == 1500);
        if (flush_left > 0) begin
            flush = 1'b1;
            flush_left--;
        end else if ((ph == 3 || ph == 2) && $urandom_range(99, 0) < 3) begin
            flush      = 1'b1;
            flush_left = $urandom_range(3, 0);
        end else begin
            flush = 1'b0;
        end
        r      = {$urandom(), $urandom(), $urandom(), $urandom()};
        s_pld  = r[W-1:0];
        s_pld[0] = ($urandom_range(99, 0) < last_pct);
        s_vld  = ($urandom_range(99, 0) < vld_pct);
        m_rdy  = ($urandom_range(99, 0) < rdy_pct);
    endtask

    task automatic compare();
        int n_pkts;
        logic [W-1:0] e_pld;
        n_pkts  = complete_pkts();
        e_s_rdy = !rst && (mstate == RUN) && (exp_q.size() < DEPTH);
`ifdef DTI_NOC_INJ_CUT_THROUGH_EN
        e_m_vld = !rst && (mstate == RUN) && (exp_q.size() > 0);
`else
        e_m_vld = !rst && (mstate == RUN) && (n_pkts > 0);
`endif
        e_pld = e_m_vld ? exp_q[0] : '0;
        check("s_rdy", W'(s_rdy), W'(e_s_rdy));
        check("m_vld", W'(m_vld), W'(e_m_vld));
        check("m_pld", m_pld, e_pld);
        check("pkt_cnt", W'(pkt_cnt), W'(n_pkts));
        check("err_long_pkt", W'(err_long_pkt), W'(exp_err));
        check("idle", W'(idle), W'((mstate == RUN) && (exp_q.size() == 0) && (pkt_flits == 0)));
        check("state", W'(dbg_state), W'(mstate));
    endtask

    // model the effect of the coming clock edge
    task automatic model_step();
        logic [W-1:0] f;
        if (rst) begin
            model_reset();
            return;
        end
        case (mstate)
            RUN: begin
                if (e_m_vld && m_rdy) void'(exp_q.pop_front());
                if (e_s_rdy && s_vld) begin
                    f = s_pld;
                    if (!f[0] && pkt_flits == MAXF - 1) begin
                        f[0]    = 1'b1;
                        exp_err = 1'b1;
                    end
                    pkt_flits = f[0] ? 0 : pkt_flits + 1;
                    exp_q.push_back(f);
                end
                if (flush) mstate = FLUSH;
            end
            FLUSH: begin
                exp_q.delete();
                pkt_flits = 0;
                mstate    = HOLD;
            end
            default: if (!flush) mstate = RUN;
        endcase
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        s_vld = 1'b0;
        s_pld = '0;
        m_rdy = 1'b0;
        model_reset();
        for (int i = 0; i < NCYC; i++) begin
            @(negedge clk);
            cyc = i;
            drive();
            #1;
            compare();
            model_step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
